// File: rtl/bp_pkg.sv
// Shared types for the branch-predictor update scheduler.
// No logic; types only.
// No flow control of its own.
package bp_pkg;

    // One resolved branch/jump event as written into the predictor tables.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] target;
        logic        taken;
        logic        is_jump;
    } bp_update_t;

    // IDLE: nothing queued; SHARE: queued work but lookups still served;
    // OFFER: head entry owns the table port until accepted.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHARE = 2'd1,
        OFFER = 2'd2
    } sched_state_e;

endpackage

// File: rtl/bp_update_fifo.sv
// Circular queue of resolution events, DEPTH entries of bp_update_t.
// Write visible at head one cycle after push; head is a combinational read.
// Caller must not push when full or pop when empty; such requests are ignored.
module bp_update_fifo
    import bp_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push_vld,
    input  bp_update_t                   push_dat,
    input  logic                         pop_vld,
    output bp_update_t                   head_dat,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    bp_update_t             mem_q [DEPTH];
    bp_update_t             mem_d [DEPTH];
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   push_ok;
    logic                   pop_ok;

    assign full     = (cnt_q == DEPTH_C);
    assign empty    = (cnt_q == '0);
    assign count    = cnt_q;
    assign head_dat = mem_q[rd_ptr_q];
    assign push_ok  = push_vld & ~full;
    assign pop_ok   = pop_vld & ~empty;

    // Next pointers, occupancy and storage; pointers wrap naturally at DEPTH (power of 2).
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = push_dat;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push_ok, pop_ok})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    // State registers; storage is cleared so the head reads zero out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/bp_update_scheduler.sv
// Queues EX branch resolutions and shares the predictor table port with fetch lookups.
// Enqueue-to-upd_valid is 2 cycles minimum; lookups may defer an update at most MAX_DEFER grants.
// res_ready drops when the queue is full (events then dropped, overflow_err set); upd_* held until upd_ready.
module bp_update_scheduler
    import bp_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int MAX_DEFER = 3
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         res_valid,
    input  logic [31:0]                  res_pc,
    input  logic [31:0]                  res_target,
    input  logic                         res_taken,
    input  logic                         res_is_jump,
    output logic                         res_ready,
    input  logic                         lk_valid,
    output logic                         lk_grant,
    output logic                         upd_valid,
    output logic [31:0]                  upd_pc,
    output logic [31:0]                  upd_target,
    output logic                         upd_taken,
    output logic                         upd_is_jump,
    input  logic                         upd_ready,
    output logic [$clog2(DEPTH+1)-1:0]   q_count,
    output logic                         overflow_err
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int DEF_W = $clog2(MAX_DEFER + 1);
    localparam logic [DEF_W-1:0] DEFER_MAX_C = DEF_W'(MAX_DEFER);
    localparam logic [DEF_W:0]   DEFER_LIM_C = (DEF_W + 1)'(MAX_DEFER);

    sched_state_e       state_q, state_d;
    logic [DEF_W-1:0]   defer_cnt_q, defer_cnt_d;
    logic               overflow_err_q, overflow_err_d;

    bp_update_t         enq_dat;
    bp_update_t         head_dat;
    logic [CNT_W-1:0]   fifo_cnt;
    logic [CNT_W-1:0]   cnt_after;
    logic               fifo_full;
    logic               fifo_empty;
    logic               enq;
    logic               deq;
    logic               defer_hit;

    assign enq_dat = '{pc: res_pc, target: res_target, taken: res_taken, is_jump: res_is_jump};

    bp_update_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push_vld (enq),
        .push_dat (enq_dat),
        .pop_vld  (deq),
        .head_dat (head_dat),
        .count    (fifo_cnt),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    // Queue handshakes; res_ready ignores a same-cycle dequeue so it depends only on state.
    always_comb begin
        res_ready = rst_n & ~fifo_full;
        enq       = res_valid & res_ready;
        deq       = upd_valid & upd_ready & ~fifo_empty;
        cnt_after = fifo_cnt + CNT_W'(enq) - CNT_W'(deq);
        defer_hit = lk_valid && (({1'b0, defer_cnt_q} + 1'b1) >= DEFER_LIM_C);
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: lookups keep the port until idle, deferral bound, or full queue.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (enq) state_d = SHARE;
            end
            SHARE: begin
                if (!lk_valid || defer_hit || fifo_full) state_d = OFFER;
            end
            OFFER: begin
                if (deq) state_d = (cnt_after != '0) ? SHARE : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: OFFER owns the table port outright, otherwise fetch gets it on request.
    always_comb begin
        upd_valid = (state_q == OFFER);
        lk_grant  = rst_n & lk_valid & (state_q != OFFER);
    end

    // Head entry is always presented; consumers qualify it with upd_valid.
    always_comb begin
        upd_pc      = head_dat.pc;
        upd_target  = head_dat.target;
        upd_taken   = head_dat.taken;
        upd_is_jump = head_dat.is_jump;
        q_count     = fifo_cnt;
    end

    // Deferral count: grows per granted lookup in SHARE, saturates, cleared on update accept.
    always_comb begin
        defer_cnt_d = defer_cnt_q;
        if ((state_q == OFFER) && deq) begin
            defer_cnt_d = '0;
        end else if ((state_q == SHARE) && lk_valid && (defer_cnt_q != DEFER_MAX_C)) begin
            defer_cnt_d = defer_cnt_q + 1'b1;
        end
    end

    // Sticky drop indicator, only reset clears it.
    always_comb begin
        overflow_err_d = overflow_err_q | (res_valid & ~res_ready);
        overflow_err   = overflow_err_q;
    end

    // Counter and error flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            defer_cnt_q    <= '0;
            overflow_err_q <= 1'b0;
        end else begin
            defer_cnt_q    <= defer_cnt_d;
            overflow_err_q <= overflow_err_d;
        end
    end

endmodule

// File: tb/tb_bp_update_scheduler.sv
// Directed bench for bp_update_scheduler with an update scoreboard.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
// A monitor pops the expected-update queue on every accepted update.
module tb_bp_update_scheduler;
    import bp_pkg::*;

    localparam int DEPTH     = 4;
    localparam int MAX_DEFER = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        res_valid;
    logic [31:0] res_pc;
    logic [31:0] res_target;
    logic        res_taken;
    logic        res_is_jump;
    logic        res_ready;
    logic        lk_valid;
    logic        lk_grant;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic [31:0] upd_target;
    logic        upd_taken;
    logic        upd_is_jump;
    logic        upd_ready;
    logic [2:0]  q_count;
    logic        overflow_err;

    int total = 0;
    int bad   = 0;
    bp_update_t exp_q[$];

    always #5 clk = ~clk;

    bp_update_scheduler #(
        .DEPTH     (DEPTH),
        .MAX_DEFER (MAX_DEFER)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .res_valid    (res_valid),
        .res_pc       (res_pc),
        .res_target   (res_target),
        .res_taken    (res_taken),
        .res_is_jump  (res_is_jump),
        .res_ready    (res_ready),
        .lk_valid     (lk_valid),
        .lk_grant     (lk_grant),
        .upd_valid    (upd_valid),
        .upd_pc       (upd_pc),
        .upd_target   (upd_target),
        .upd_taken    (upd_taken),
        .upd_is_jump  (upd_is_jump),
        .upd_ready    (upd_ready),
        .q_count      (q_count),
        .overflow_err (overflow_err)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic ev(input logic [31:0] pc, input logic [31:0] tgt, input logic tk,
                      input logic jp, input logic accepted);
        res_valid   = 1'b1;
        res_pc      = pc;
        res_target  = tgt;
        res_taken   = tk;
        res_is_jump = jp;
        if (accepted) exp_q.push_back('{pc: pc, target: tgt, taken: tk, is_jump: jp});
    endtask

    task automatic wait_valid(input int lim, input string nm);
        int n;
        n = 0;
        @(negedge clk);
        while (upd_valid !== 1'b1 && n < lim) begin
            @(negedge clk);
            n++;
        end
        chk(nm, 32'(upd_valid), 32'd1);
    endtask

    // Scoreboard: every accepted update must match the oldest expected entry.
    always @(negedge clk) begin : mon
        bp_update_t e;
        if (rst_n === 1'b1 && upd_valid === 1'b1 && upd_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_update: got pc=%h expected no update", upd_pc);
            end else begin
                e = exp_q.pop_front();
                chk("upd_pc", upd_pc, e.pc);
                chk("upd_target", upd_target, e.target);
                chk("upd_flags", 32'({upd_taken, upd_is_jump}), 32'({e.taken, e.is_jump}));
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int n;
        rst_n = 1'b0; res_valid = 1'b1; res_pc = 32'h0; res_target = 32'h0;
        res_taken = 1'b0; res_is_jump = 1'b0; lk_valid = 1'b1; upd_ready = 1'b0;

        // Reset state: grant and ready forced low, queue and flags clear.
        #12;
        chk("rst_lk_grant", 32'(lk_grant), 32'd0);
        chk("rst_res_ready", 32'(res_ready), 32'd0);
        chk("rst_q_count", 32'(q_count), 32'd0);
        chk("rst_upd_valid", 32'(upd_valid), 32'd0);
        chk("rst_upd_pc", upd_pc, 32'd0);
        chk("rst_overflow", 32'(overflow_err), 32'd0);
        res_valid = 1'b0; lk_valid = 1'b0;
        cyc();
        rst_n = 1'b1;
        cyc();

        // 1: single event without lookups reaches upd_valid two cycles later.
        ev(32'h10, 32'h40, 1'b1, 1'b0, 1'b1);
        smp(); chk("t1_c0_upd_valid", 32'(upd_valid), 32'd0);
        chk("t1_c0_res_ready", 32'(res_ready), 32'd1);
        cyc(); res_valid = 1'b0;
        smp(); chk("t1_c1_upd_valid", 32'(upd_valid), 32'd0);
        chk("t1_c1_q_count", 32'(q_count), 32'd1);
        cyc(); upd_ready = 1'b1;
        smp(); chk("t1_c2_upd_valid", 32'(upd_valid), 32'd1);
        cyc(); upd_ready = 1'b0;
        smp(); chk("t1_c3_q_count", 32'(q_count), 32'd0);
        chk("t1_c3_state", 32'(dut.state_q), 32'(IDLE));
        chk("t1_c3_upd_valid", 32'(upd_valid), 32'd0);
        cyc();

        // 2: lookups held high; update forced onto the port after MAX_DEFER deferrals.
        lk_valid = 1'b1;
        ev(32'h100, 32'h200, 1'b0, 1'b0, 1'b1);
        for (int c = 0; c < 4; c++) begin
            smp();
            chk($sformatf("t2_c%0d_lk_grant", c), 32'(lk_grant), 32'd1);
            chk($sformatf("t2_c%0d_upd_valid", c), 32'(upd_valid), 32'd0);
            cyc();
            res_valid = 1'b0;
        end
        upd_ready = 1'b1;
        smp(); chk("t2_c4_lk_grant", 32'(lk_grant), 32'd0);
        chk("t2_c4_upd_valid", 32'(upd_valid), 32'd1);
        cyc(); upd_ready = 1'b0;
        smp(); chk("t2_c5_lk_grant", 32'(lk_grant), 32'd1);
        chk("t2_c5_q_count", 32'(q_count), 32'd0);
        cyc();

        // 3: five back-to-back events into a stalled queue; the fifth is dropped.
        lk_valid = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            ev(32'h1000 + i * 4, 32'h2000 + i * 8, i[0], (i == 3), (i <= 4));
            smp();
            chk($sformatf("t3_ev%0d_res_ready", i), 32'(res_ready), (i <= 4) ? 32'd1 : 32'd0);
            chk($sformatf("t3_ev%0d_q_count", i), 32'(q_count), 32'(i - 1));
            cyc();
        end
        res_valid = 1'b0;
        smp(); chk("t3_overflow_set", 32'(overflow_err), 32'd1);
        chk("t3_full_count", 32'(q_count), 32'd4);
        cyc(); cyc(); cyc();
        smp(); chk("t3_overflow_sticky", 32'(overflow_err), 32'd1);
        cyc();
        upd_ready = 1'b1;
        n = 0;
        smp();
        while (q_count !== 3'd0 && n < 30) begin
            cyc(); smp(); n++;
        end
        chk("t3_drained", 32'(q_count), 32'd0);
        chk("t3_overflow_after_drain", 32'(overflow_err), 32'd1);
        cyc(); upd_ready = 1'b0;

        // 4: backpressure in OFFER keeps head bit-stable and lookups stalled.
        lk_valid = 1'b1;
        ev(32'hABC0, 32'hDEF0, 1'b1, 1'b1, 1'b1);
        cyc(); res_valid = 1'b0;
        wait_valid(10, "t4_reach_offer");
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("t4_hold%0d_pc", i), upd_pc, 32'hABC0);
            chk($sformatf("t4_hold%0d_tgt", i), upd_target, 32'hDEF0);
            chk($sformatf("t4_hold%0d_flags", i), 32'({upd_taken, upd_is_jump}), 32'd3);
            chk($sformatf("t4_hold%0d_lk_grant", i), 32'(lk_grant), 32'd0);
            chk($sformatf("t4_hold%0d_upd_valid", i), 32'(upd_valid), 32'd1);
            cyc();
            if (i < 4) smp();
        end
        upd_ready = 1'b1;
        smp(); chk("t4_accept_lk_grant", 32'(lk_grant), 32'd0);
        cyc(); upd_ready = 1'b0;
        smp(); chk("t4_after_lk_grant", 32'(lk_grant), 32'd1);
        chk("t4_after_upd_valid", 32'(upd_valid), 32'd0);
        cyc();

        // 5: enqueue and dequeue together at occupancy 1.
        lk_valid = 1'b0;
        ev(32'h500, 32'h540, 1'b0, 1'b0, 1'b1);
        cyc(); res_valid = 1'b0;
        smp(); chk("t5_c1_state", 32'(dut.state_q), 32'(SHARE));
        cyc();
        ev(32'h600, 32'h640, 1'b1, 1'b0, 1'b1);
        upd_ready = 1'b1;
        smp(); chk("t5_c2_upd_valid", 32'(upd_valid), 32'd1);
        chk("t5_c2_q_count", 32'(q_count), 32'd1);
        cyc(); res_valid = 1'b0; upd_ready = 1'b0;
        smp(); chk("t5_c3_q_count", 32'(q_count), 32'd1);
        chk("t5_c3_state", 32'(dut.state_q), 32'(SHARE));
        chk("t5_c3_head_pc", upd_pc, 32'h600);
        cyc(); upd_ready = 1'b1;
        smp(); chk("t5_c4_upd_valid", 32'(upd_valid), 32'd1);
        cyc(); upd_ready = 1'b0;
        smp(); chk("t5_c5_q_count", 32'(q_count), 32'd0);
        chk("t5_c5_state", 32'(dut.state_q), 32'(IDLE));
        cyc();

        // 6: asynchronous reset while three entries wait in OFFER.
        for (int i = 0; i < 3; i++) begin
            ev(32'h900 + i * 4, 32'h980 + i * 4, 1'b1, 1'b0, 1'b1);
            cyc();
        end
        res_valid = 1'b0;
        smp(); chk("t6_pre_upd_valid", 32'(upd_valid), 32'd1);
        chk("t6_pre_q_count", 32'(q_count), 32'd3);
        chk("t6_pre_overflow", 32'(overflow_err), 32'd1);
        #2;
        rst_n = 1'b0; lk_valid = 1'b1;
        exp_q.delete();
        #1;
        chk("t6_rst_q_count", 32'(q_count), 32'd0);
        chk("t6_rst_upd_valid", 32'(upd_valid), 32'd0);
        chk("t6_rst_overflow", 32'(overflow_err), 32'd0);
        chk("t6_rst_lk_grant", 32'(lk_grant), 32'd0);
        chk("t6_rst_res_ready", 32'(res_ready), 32'd0);
        cyc();
        rst_n = 1'b1;
        smp(); chk("t6_rel_lk_grant", 32'(lk_grant), 32'd1);
        chk("t6_rel_q_count", 32'(q_count), 32'd0);
        chk("t6_rel_state", 32'(dut.state_q), 32'(IDLE));
        chk("t6_rel_res_ready", 32'(res_ready), 32'd1);
        cyc();
        lk_valid = 1'b0; upd_ready = 1'b1;
        ev(32'h777, 32'h7F0, 1'b0, 1'b1, 1'b1);
        cyc(); res_valid = 1'b0;
        cyc();
        smp(); chk("t6_post_upd_valid", 32'(upd_valid), 32'd1);
        cyc(); upd_ready = 1'b0;
        smp(); chk("t6_post_q_count", 32'(q_count), 32'd0);

        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
